// File: rtl/ysyx_24100006_regfile_sb.sv
// rtl/ysyx_24100006_regfile_sb.sv - GPR file, machine CSR bank and RAW scoreboard fed by WBU commits
// Commits land at the accepting edge; an irq commit spends one extra cycle in S_TRAP updating mcause/mstatus.
module ysyx_24100006_regfile_sb #(
  parameter int          NR_GPR  = 16,
  parameter int          SB_W    = 2,
  parameter logic [31:0] MARCHID = 32'h016FBCA6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_in_valid,
  output logic        wb_in_ready,
  input  logic        irq_WD,
  input  logic [7:0]  irq_no_WD,
  input  logic        Gpr_Write_WD,
  input  logic        Csr_Write_WD,
  input  logic [3:0]  Gpr_Write_Addr_WD,
  input  logic [11:0] Csr_Write_Addr_WD,
  input  logic [31:0] wdata_gpr,
  input  logic [31:0] wdata_csr,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [11:0] csr_raddr,
  output logic [31:0] rdata_csr,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  input  logic        issue_valid,
  input  logic        issue_wen,
  input  logic [3:0]  issue_rd,
  output logic        issue_ready,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        sb_err
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [31:0] MVENDORID     = 32'h79737978;

  typedef enum logic {S_IDLE, S_TRAP} state_t;

  state_t            state, state_n;
  logic              ready_q;
  logic [31:0]       gpr [NR_GPR];
  logic [31:0]       mstatus, mcause;
  logic [31:0]       mstatus_n, mtvec_n, mepc_n, mcause_n;
  logic [7:0]        irq_no_q;
  logic [SB_W-1:0]   cnt   [NR_GPR];
  logic [SB_W-1:0]   cnt_n [NR_GPR];
  logic              sb_err_set;
  logic              accept, gpr_we, irq_acc;

  assign wb_in_ready = ready_q;
  assign accept      = wb_in_valid & ready_q;
  assign gpr_we      = accept & Gpr_Write_WD & (Gpr_Write_Addr_WD != 4'd0);
  assign irq_acc     = accept & irq_WD;

  always_comb begin
    state_n   = state;
    mstatus_n = mstatus;
    mtvec_n   = mtvec;
    mepc_n    = mepc;
    mcause_n  = mcause;
    case (state)
      S_IDLE: begin
        if (irq_acc) begin
          mepc_n  = wdata_csr;
          state_n = S_TRAP;
        end else if (accept && Csr_Write_WD) begin
          case (Csr_Write_Addr_WD)
            CSR_MSTATUS: mstatus_n = wdata_csr;
            CSR_MTVEC:   mtvec_n   = wdata_csr;
            CSR_MEPC:    mepc_n    = wdata_csr;
            CSR_MCAUSE:  mcause_n  = wdata_csr;
            default:     ;
          endcase
        end
      end
      S_TRAP: begin
        mcause_n     = {24'b0, irq_no_q};
        mstatus_n[7] = mstatus[3];
        mstatus_n[3] = 1'b0;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reads see the value this edge will store (write-first)
  always_comb begin
    rdata_csr = 32'b0;
    case (csr_raddr)
      CSR_MSTATUS:   rdata_csr = mstatus_n;
      CSR_MTVEC:     rdata_csr = mtvec_n;
      CSR_MEPC:      rdata_csr = mepc_n;
      CSR_MCAUSE:    rdata_csr = mcause_n;
      CSR_MVENDORID: rdata_csr = MVENDORID;
      CSR_MARCHID:   rdata_csr = MARCHID;
      default:       ;
    endcase
  end

  assign rs1_data = (rs1_addr == 4'd0) ? 32'b0 :
                    (gpr_we && Gpr_Write_Addr_WD == rs1_addr) ? wdata_gpr : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 4'd0) ? 32'b0 :
                    (gpr_we && Gpr_Write_Addr_WD == rs2_addr) ? wdata_gpr : gpr[rs2_addr];

  assign issue_ready = !(issue_wen && (cnt[issue_rd] == '1));
  assign rs1_busy    = (cnt[rs1_addr] != '0) && (rs1_addr != 4'd0);
  assign rs2_busy    = (cnt[rs2_addr] != '0) && (rs2_addr != 4'd0);

  // A simultaneous issue and commit to one register cancel out
  always_comb begin
    sb_err_set = 1'b0;
    for (int r = 0; r < NR_GPR; r++) begin
      logic inc, dec;
      inc = issue_valid && issue_ready && issue_wen && (issue_rd == 4'(r)) && (r != 0);
      dec = gpr_we && (Gpr_Write_Addr_WD == 4'(r));
      cnt_n[r] = cnt[r];
      if (dec && cnt[r] == '0) sb_err_set = 1'b1;
      if (inc && !dec)
        cnt_n[r] = cnt[r] + SB_W'(1);
      else if (dec && !inc && cnt[r] != '0)
        cnt_n[r] = cnt[r] - SB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      mstatus  <= 32'h1800;
      mtvec    <= 32'b0;
      mepc     <= 32'b0;
      mcause   <= 32'b0;
      irq_no_q <= 8'b0;
      sb_err   <= 1'b0;
      for (int r = 0; r < NR_GPR; r++) begin
        gpr[r] <= 32'b0;
        cnt[r] <= '0;
      end
    end else begin
      state   <= state_n;
      ready_q <= (state_n == S_IDLE);
      mstatus <= mstatus_n;
      mtvec   <= mtvec_n;
      mepc    <= mepc_n;
      mcause  <= mcause_n;
      if (irq_acc)    irq_no_q <= irq_no_WD;
      if (sb_err_set) sb_err   <= 1'b1;
      if (gpr_we)     gpr[Gpr_Write_Addr_WD] <= wdata_gpr;
      for (int r = 0; r < NR_GPR; r++) cnt[r] <= cnt_n[r];
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_regfile_sb.sv
// tb/tb_ysyx_24100006_regfile_sb.sv - directed plus random checks against an architectural model
module tb_ysyx_24100006_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_in_valid, wb_in_ready, irq_WD;
  logic [7:0]  irq_no_WD;
  logic        Gpr_Write_WD, Csr_Write_WD;
  logic [3:0]  Gpr_Write_Addr_WD;
  logic [11:0] Csr_Write_Addr_WD;
  logic [31:0] wdata_gpr, wdata_csr;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [11:0] csr_raddr;
  logic [31:0] rdata_csr, mtvec, mepc;
  logic        issue_valid, issue_wen;
  logic [3:0]  issue_rd;
  logic        issue_ready, rs1_busy, rs2_busy, sb_err;

  always #5 clk = ~clk;

  ysyx_24100006_regfile_sb dut (
    .clk(clk), .reset(reset),
    .wb_in_valid(wb_in_valid), .wb_in_ready(wb_in_ready),
    .irq_WD(irq_WD), .irq_no_WD(irq_no_WD),
    .Gpr_Write_WD(Gpr_Write_WD), .Csr_Write_WD(Csr_Write_WD),
    .Gpr_Write_Addr_WD(Gpr_Write_Addr_WD), .Csr_Write_Addr_WD(Csr_Write_Addr_WD),
    .wdata_gpr(wdata_gpr), .wdata_csr(wdata_csr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_raddr(csr_raddr), .rdata_csr(rdata_csr),
    .mtvec(mtvec), .mepc(mepc),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_err(sb_err)
  );

  localparam int SB_MAX = 3;

  int checks = 0;
  int errors = 0;

  // Architectural model: m_* is the committed state, n_* the state after the pending edge
  logic [31:0] m_gpr [16], n_gpr [16];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic [31:0] n_mstatus, n_mtvec, n_mepc, n_mcause;
  int          m_cnt [16], n_cnt [16];
  bit          m_err, n_err, m_trap, n_trap;
  logic [7:0]  m_irq, n_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_gpr[i] = 32'b0;
      m_cnt[i] = 0;
    end
    m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    m_err = 0; m_trap = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] n_csr(input logic [11:0] a);
    case (a)
      12'h300: return n_mstatus;
      12'h305: return n_mtvec;
      12'h341: return n_mepc;
      12'h342: return n_mcause;
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h016FBCA6;
      default: return 32'b0;
    endcase
  endfunction

  task automatic compute_next();
    bit acc, issued, commit;
    n_gpr = m_gpr; n_cnt = m_cnt;
    n_mstatus = m_mstatus; n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
    n_err = m_err; n_trap = m_trap; n_irq = m_irq;
    acc = wb_in_valid && !m_trap;
    if (m_trap) begin
      n_mcause = {24'b0, m_irq};
      n_mstatus[7] = m_mstatus[3];
      n_mstatus[3] = 1'b0;
      n_trap = 0;
    end else if (acc) begin
      if (Gpr_Write_WD && Gpr_Write_Addr_WD != 0) n_gpr[Gpr_Write_Addr_WD] = wdata_gpr;
      if (irq_WD) begin
        n_mepc = wdata_csr; n_irq = irq_no_WD; n_trap = 1;
      end else if (Csr_Write_WD) begin
        case (Csr_Write_Addr_WD)
          12'h300: n_mstatus = wdata_csr;
          12'h305: n_mtvec   = wdata_csr;
          12'h341: n_mepc    = wdata_csr;
          12'h342: n_mcause  = wdata_csr;
          default: ;
        endcase
      end
    end
    issued = issue_valid && issue_wen && issue_rd != 0 && m_cnt[issue_rd] < SB_MAX;
    commit = acc && Gpr_Write_WD && Gpr_Write_Addr_WD != 0;
    if (commit && m_cnt[Gpr_Write_Addr_WD] == 0) n_err = 1;
    if (!(issued && commit && issue_rd == Gpr_Write_Addr_WD)) begin
      if (issued) n_cnt[issue_rd]++;
      if (commit && m_cnt[Gpr_Write_Addr_WD] > 0) n_cnt[Gpr_Write_Addr_WD]--;
    end
  endtask

  task automatic check_regs();
    chk("wb_in_ready", {31'b0, wb_in_ready}, {31'b0, !m_trap});
    chk("mtvec", mtvec, m_mtvec);
    chk("mepc", mepc, m_mepc);
    chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, !(issue_wen && m_cnt[issue_rd] == SB_MAX)});
    chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, rs1_addr != 0 && m_cnt[rs1_addr] != 0});
    chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, rs2_addr != 0 && m_cnt[rs2_addr] != 0});
  endtask

  // Inputs are set at the falling edge; combinational outputs checked before the rising edge
  task automatic tick();
    #1;
    compute_next();
    chk("rs1_data", rs1_data, n_gpr[rs1_addr]);
    chk("rs2_data", rs2_data, n_gpr[rs2_addr]);
    check_regs();
    if (!m_trap) chk("rdata_csr", rdata_csr, n_csr(csr_raddr));
    m_gpr = n_gpr; m_cnt = n_cnt;
    m_mstatus = n_mstatus; m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
    m_err = n_err; m_trap = n_trap; m_irq = n_irq;
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic clear();
    wb_in_valid = 0; irq_WD = 0; irq_no_WD = 0;
    Gpr_Write_WD = 0; Csr_Write_WD = 0; Gpr_Write_Addr_WD = 0; Csr_Write_Addr_WD = 0;
    wdata_gpr = 0; wdata_csr = 0;
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
  endtask

  task automatic wb(input logic irq, input logic [7:0] no, input logic gwe, input logic [3:0] ga,
                    input logic [31:0] gd, input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
    wb_in_valid = 1; irq_WD = irq; irq_no_WD = no;
    Gpr_Write_WD = gwe; Gpr_Write_Addr_WD = ga; wdata_gpr = gd;
    Csr_Write_WD = cwe; Csr_Write_Addr_WD = ca; wdata_csr = cd;
  endtask

  task automatic issue(input logic [3:0] rd);
    issue_valid = 1; issue_wen = 1; issue_rd = rd;
  endtask

  logic [11:0] csr_list [7];

  initial begin
    csr_list = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0};
    reset = 0;
    clear();
    rs1_addr = 0; rs2_addr = 0; csr_raddr = 12'h300;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_ready", {31'b0, wb_in_ready}, 32'd1);
    chk("rst_mstatus", rdata_csr, 32'h1800);
    chk("rst_mtvec", mtvec, 32'd0);
    chk("rst_sb_err", {31'b0, sb_err}, 32'd0);
    reset = 1;

    // GPR commit with bypass
    issue(5); tick(); clear();
    rs1_addr = 5; wb(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick(); clear();
    chk("x5_bypass", n_gpr[5], 32'hDEADBEEF);
    tick();
    // x0 write dropped
    rs1_addr = 0; wb(0, 0, 1, 0, 32'h1234, 0, 0, 0); tick(); clear(); tick();
    // CSR map
    csr_raddr = 12'h305; wb(0, 0, 0, 0, 0, 1, 12'h305, 32'h8000_0100); tick(); clear();
    csr_raddr = 12'hF11; wb(0, 0, 0, 0, 0, 1, 12'hF11, 32'h0); tick(); clear();
    csr_raddr = 12'h7C0; wb(0, 0, 0, 0, 0, 1, 12'h7C0, 32'h55); tick(); clear();
    csr_raddr = 12'hF12; tick();
    // Trap entry with MIE set, valid held during S_TRAP
    csr_raddr = 12'h300; wb(0, 0, 0, 0, 0, 1, 12'h300, 32'h1808); tick(); clear();
    csr_raddr = 12'h342; wb(1, 8'd11, 0, 0, 0, 1, 12'h305, 32'h8000_0040); tick();
    wb(0, 0, 0, 0, 0, 1, 12'h341, 32'h1111_2222); tick(); tick(); clear();
    csr_raddr = 12'h300; tick();
    // Scoreboard saturation and cancelling
    rs1_addr = 3; rs2_addr = 3;
    for (int i = 0; i < 4; i++) begin issue(3); tick(); end
    clear(); wb(0, 0, 1, 3, 32'h33, 0, 0, 0); tick();
    issue(3); tick(); clear();
    for (int i = 0; i < 3; i++) begin wb(0, 0, 1, 3, 32'h40 + i, 0, 0, 0); tick(); end
    clear(); tick();
    // Commit with empty counter, then async reset during S_TRAP
    rs1_addr = 7; wb(0, 0, 1, 7, 32'h77, 0, 0, 0); tick(); clear();
    csr_raddr = 12'h342; wb(1, 8'd3, 0, 0, 0, 0, 0, 32'h8000_0080); tick(); clear();
    #2 reset = 0;
    #1;
    model_reset();
    chk("arst_ready", {31'b0, wb_in_ready}, 32'd1);
    chk("arst_mepc", mepc, 32'd0);
    chk("arst_mtvec", mtvec, 32'd0);
    chk("arst_sb_err", {31'b0, sb_err}, 32'd0);
    chk("arst_x7", rs1_data, 32'd0);
    @(posedge clk); #1;
    chk("arst_mcause", rdata_csr, 32'd0);
    @(negedge clk);
    reset = 1;
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      wb_in_valid = $urandom_range(0, 1);
      irq_WD = ($urandom_range(0, 15) == 0);
      irq_no_WD = 8'($urandom);
      Gpr_Write_WD = $urandom_range(0, 1);
      Gpr_Write_Addr_WD = 4'($urandom);
      wdata_gpr = $urandom;
      Csr_Write_WD = $urandom_range(0, 1);
      Csr_Write_Addr_WD = csr_list[$urandom_range(0, 6)];
      wdata_csr = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_wen = ($urandom_range(0, 3) != 0);
      issue_rd = 4'($urandom);
      rs1_addr = 4'($urandom);
      rs2_addr = 4'($urandom);
      csr_raddr = csr_list[$urandom_range(0, 6)];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
